// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-input round-robin picker, combinational, one-hot grant
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  gnt_e       last_gnt,
  output logic [1:0] gnt
);

  // gnt[0] = fetch side, gnt[1] = data side; on a tie the side not served last wins
  always_comb begin
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (last_gnt == GNT_D) ? 2'b01 : 2'b10;
    end else if (req_i) begin
      gnt = 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port variable-latency memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  gnt_e          rr_q, rr_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]    gnt;

  arb_rr2 u_rr (
    .req_i    (i_req),
    .req_d    (d_req),
    .last_gnt (rr_q),
    .gnt      (gnt)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d     = BUSY_I;
          rr_d        = GNT_I;
          wd_d        = '0;
          mem_req_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end else if (gnt[1]) begin
          state_d     = BUSY_D;
          rr_d        = GNT_D;
          wd_d        = '0;
          mem_req_d   = 1'b1;
          mem_wen_d   = d_wen;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end
      end

      BUSY_I, BUSY_D: begin
        // a late ack on the watchdog's final cycle still wins over the abort
        if (mem_ack || (wd_q == WD_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_wen_d = 1'b0;
          err_d     = !mem_ack;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= GNT_D;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_wen = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        side;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  typedef struct {
    logic        side;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mdata;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int          hi_cnt = 0;
  int          mem_lat = 0;
  logic        mem_use_fn = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_wen = 1'b0;
  logic        stable = 1'b1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer plus variable-latency memory model
  exp_t e;
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({d_ack, i_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_side", 32'({d_ack, i_ack}), e.side ? 32'd2 : 32'd1);
        check("err", 32'(err), 32'(e.err));
        if (e.rd) check("rdata", e.side ? d_rdata : i_rdata, e.rdata);
        check("mem_addr", cap_addr, e.addr);
        check("mem_wen", 32'(cap_wen), 32'(e.side && !e.rd));
        if (!e.rd) check("mem_wdata", cap_wdata, e.wdata);
        check("mem_stable", 32'(stable), 32'd1);
        check("mem_req_cycles", 32'(hi_cnt), 32'(e.cycles));
        check("mem_req_low_in_ack", 32'(mem_req), 32'd0);
      end
    end else if (err) begin
      check("stray_err", 32'(err), 32'd0);
    end

    mem_ack = 1'b0;
    if (mem_req) begin
      if (hi_cnt == 0) begin
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wen   = mem_wen;
        stable    = 1'b1;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wen !== cap_wen) begin
        stable = 1'b0;
      end
      hi_cnt++;
      if (hi_cnt == mem_lat + 1) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_use_fn ? mem_fn(mem_addr) : mem_data;
      end
    end else begin
      hi_cnt = 0;
    end
  end

  task automatic wait_ack(output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t x;
    bit   got;
    int   lat;
    x.side   = v.side;
    x.rd     = !(v.side && v.wen);
    x.addr   = v.addr;
    x.wdata  = v.wdata;
    x.err    = (v.lat + 1 > TO);
    x.rdata  = x.err ? 32'd0 : v.mdata;
    x.cycles = x.err ? TO : v.lat + 1;
    @(negedge clk);
    mem_use_fn = 1'b0;
    mem_data   = v.mdata;
    mem_lat    = v.lat;
    sb.push_back(x);
    if (v.side) begin
      d_req = 1'b1; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    wait_ack(got, lat);
    i_req = 1'b0;
    d_req = 1'b0;
    if (got) check("latency", 32'(lat), 32'(x.cycles + 1));
    repeat (2) @(negedge clk);
  endtask

  // Both sides held high for n transactions; grants must alternate starting with I
  task automatic contend(input int n);
    exp_t x;
    bit   got;
    int   lat;
    int   ni = 0;
    int   nd = 0;
    for (int k = 0; k < n; k++) begin
      x.side   = k[0];
      x.rd     = 1'b1;
      x.addr   = x.side ? 32'h2000 + 32'(4 * nd) : 32'h1000 + 32'(4 * ni);
      x.wdata  = '0;
      x.rdata  = mem_fn(x.addr);
      x.err    = 1'b0;
      x.cycles = 1;
      if (x.side) nd++; else ni++;
      sb.push_back(x);
    end
    @(negedge clk);
    mem_use_fn = 1'b1;
    mem_lat    = 0;
    i_addr = 32'h1000; d_addr = 32'h2000; d_wen = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_ack(got, lat);
      if (!got) break;
      if (k == n - 1) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end else if (i_ack) begin
        i_addr = i_addr + 32'd4;
      end else begin
        d_addr = d_addr + 32'd4;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[8];
  bit   seen;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1,    32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 2,    32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         0,    32'h0BAD_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         1000, 32'h7777_7777};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         0,    32'h1111_2222};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0,         TO-1, 32'hCAFE_0001};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0,         1000, 32'h3333_4444};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0104, 32'hA5A5_5A5A, TO-2, 32'h0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_acks", 32'({err, d_ack, i_ack}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    contend(4);

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // reset during BUSY_I: request is dropped with no ack or err
    @(negedge clk);
    mem_use_fn = 1'b0;
    mem_lat = 1000;
    i_addr = 32'h40;
    i_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("busy_i_reached", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_no_ack", 32'({err, d_ack, i_ack}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_quiet", 32'({mem_req, err, d_ack, i_ack}), 32'd0);

    contend(2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
